// File: rtl/if_fetch_unit.sv
// Byte-serial instruction fetch unit.
// Assembles INSN_BYTES little-endian bytes from a byte-wide instruction memory
// into one instruction, then presents it downstream with a valid/ready handshake.
// A redirect restarts fetching at a new PC and discards any partial instruction.
module if_fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     INSN_BYTES = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    mem_req,
   output logic [XLEN-1:0]         mem_addr,
   input  logic                    mem_ack,
   input  logic [7:0]              mem_rdata,
   input  logic                    redirect_valid,
   input  logic [XLEN-1:0]         redirect_pc,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [8*INSN_BYTES-1:0] inst,
   output logic [XLEN-1:0]         inst_pc,
   output logic                    inst_misaligned,
   output logic [31:0]             insn_count
);

   localparam int unsigned       CNT_W      = $clog2(INSN_BYTES);
   localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(INSN_BYTES - 1);
   localparam logic [XLEN-1:0]   ALIGN_MASK = XLEN'(INSN_BYTES - 1);
   localparam logic [XLEN-1:0]   PC_STEP    = XLEN'(INSN_BYTES);

   typedef enum logic [0:0] {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [XLEN-1:0]         pc_q, pc_d;
   logic [XLEN-1:0]         mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic [8*INSN_BYTES-1:0] inst_q, inst_d;
   logic [XLEN-1:0]         inst_pc_q, inst_pc_d;
   logic                    inst_mis_q, inst_mis_d;
   logic [31:0]             insn_count_q, insn_count_d;

   // True when the address is not a multiple of the instruction size.
   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return (addr & ALIGN_MASK) != '0;
   endfunction

   // Next-state logic: redirect wins over byte acceptance and the handshake,
   // but a handshake coinciding with a redirect still counts the instruction.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      byte_cnt_d   = byte_cnt_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_mis_d   = inst_mis_q;
      insn_count_d = insn_count_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc;
         byte_cnt_d = '0;
         state_d    = ST_FETCH;
         if ((state_q == ST_HOLD) && inst_ready) begin
            insn_count_d = insn_count_q + 32'd1;
         end else begin
            insn_count_d = insn_count_q;
         end
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (mem_ack) begin
                  inst_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     state_d    = ST_HOLD;
                     inst_pc_d  = pc_q;
                     inst_mis_d = is_misaligned(pc_q);
                  end else begin
                     byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (inst_ready) begin
                  pc_d         = pc_q + PC_STEP;
                  state_d      = ST_FETCH;
                  insn_count_d = insn_count_q + 32'd1;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d    = ST_FETCH;
               byte_cnt_d = '0;
            end
         endcase
      end
      // Request address is precomputed so it leaves a flop; it wraps naturally.
      mem_addr_d = pc_d + XLEN'(byte_cnt_d);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         mem_addr_q   <= RESET_PC;
         byte_cnt_q   <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_mis_q   <= 1'b0;
         insn_count_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         mem_addr_q   <= mem_addr_d;
         byte_cnt_q   <= byte_cnt_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_mis_q   <= inst_mis_d;
         insn_count_q <= insn_count_d;
      end
   end

   // Requests are suppressed while reset is asserted so memory never sees a stale address.
   assign mem_req         = (state_q == ST_FETCH) && !rst;
   assign mem_addr        = mem_addr_q;
   assign inst_valid      = (state_q == ST_HOLD);
   assign inst            = inst_q;
   assign inst_pc         = inst_pc_q;
   assign inst_misaligned = inst_mis_q;
   assign insn_count      = insn_count_q;

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width in bits.
REQ-002 Parameter INSN_BYTES, default 4: bytes per instruction; power of two, 2..8.
REQ-003 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 mem_req  output  1: byte read request to instruction memory.
REQ-007 mem_addr  output  XLEN: byte address of the current request.
REQ-008 mem_ack  input  1: memory returns mem_rdata this cycle.
REQ-009 mem_rdata  input  8: returned byte.
REQ-010 redirect_valid  input  1: branch or jump redirect.
REQ-011 redirect_pc  input  XLEN: redirect target.
REQ-012 inst_valid  output  1: assembled instruction available.
REQ-013 inst_ready  input  1: downstream accepts instruction.
REQ-014 inst  output  8*INSN_BYTES: assembled instruction, little-endian.
REQ-015 inst_pc  output  XLEN: address of the first byte of inst.
REQ-016 inst_misaligned  output  1: inst_pc is not INSN_BYTES-aligned.
REQ-017 insn_count  output  32: count of accepted instructions.

Function
REQ-018 Two states: FETCH (requesting bytes) and HOLD (presenting an instruction).
REQ-019 In FETCH: mem_req=1, mem_addr=pc+byte_cnt (mod 2^XLEN); in HOLD: mem_req=0.
REQ-020 mem_addr and mem_req hold stable until mem_ack; mem_ack sampled only while mem_req=1.
REQ-021 A zero-wait memory asserts mem_ack in the same cycle as mem_req; the block accepts this.
REQ-022 On an accepted ack: byte stored at inst[8*byte_cnt +: 8], byte_cnt increments.
REQ-023 Ack with byte_cnt=INSN_BYTES-1: byte_cnt clears, state -> HOLD, inst_valid=1 from next cycle.
REQ-024 In HOLD: inst, inst_pc and inst_misaligned stay stable until inst_valid&inst_ready.
REQ-025 On handshake without redirect: pc <= pc+INSN_BYTES (mod 2^XLEN), state -> FETCH, inst_valid=0 next cycle, insn_count+1 (wraps at 2^32).
REQ-026 Zero-wait throughput: one instruction per INSN_BYTES+1 cycles; first mem_req the cycle after rst falls.
REQ-027 redirect_valid overrides everything except rst: pc <= redirect_pc, byte_cnt <= 0, state -> FETCH, inst_valid=0 next cycle.
REQ-028 A mem_ack in the same cycle as redirect_valid is discarded; partial bytes are dropped.
REQ-029 Redirect with a HOLD handshake in the same cycle: the instruction counts as accepted (insn_count+1), but the next pc is redirect_pc.
REQ-030 Misaligned redirect_pc is accepted; bytes are fetched from the exact address and inst_misaligned=1 with that instruction.
REQ-031 inst_ready while inst_valid=0 has no effect.

Reset
REQ-032 When rst=1 at a rising edge: pc=RESET_PC, byte_cnt=0, state=FETCH, inst=0, inst_pc=0, inst_valid=0, inst_misaligned=0, insn_count=0.
REQ-033 mem_req=0 during any cycle with rst=1; a mid-fetch or mid-HOLD reset drops all partial or held data.
REQ-034 rst takes priority over redirect_valid, mem_ack and inst_ready.

Verification
REQ-035 Zero-wait memory, bytes 13,00,00,00 at addr 0, inst_ready=1 -> inst=0x00000013, inst_pc=0 valid in cycle 5 after reset; next mem_addr=4.
REQ-036 mem_ack delayed 3 cycles per byte -> mem_addr stable while waiting; inst assembled correctly; valid after 16 cycles.
REQ-037 inst_ready=0 for 10 cycles in HOLD -> inst and inst_pc stable, mem_req=0, insn_count unchanged; release -> insn_count+1.
REQ-038 redirect_pc=0x100 asserted after 2 bytes acked -> those bytes dropped, next mem_addr=0x100, inst_pc=0x100.
REQ-039 Redirect and handshake in the same cycle -> insn_count+1, next mem_addr=redirect_pc; redirect to 0x102 -> inst_misaligned=1.
REQ-040 pc=0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1; next inst_pc=0x00000002.
